// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - load/store control stage, one transaction in flight (optional MISALIGN_TRAP_EN)
module lsu_ctrl #(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              mem_ren,
    output logic [ADDR_W-1:0] mem_raddr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_wmask
);

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    localparam logic [3:0] LAST_CNT = 4'(MEM_LAT - 1);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [2:0]        funct3_q, funct3_d;
    logic              req_ready_q, req_ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
    logic              resp_err_q, resp_err_d;
    logic              mem_ren_q, mem_ren_d;
    logic [ADDR_W-1:0] mem_raddr_q, mem_raddr_d;
    logic              mem_wen_q, mem_wen_d;
    logic [ADDR_W-1:0] mem_waddr_q, mem_waddr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]        mem_wmask_q, mem_wmask_d;
    logic              req_misaligned;

    function automatic logic [DATA_W-1:0] load_extend(input logic [2:0]        f3,
                                                      input logic [DATA_W-1:0] dw,
                                                      input logic [2:0]        lane);
        logic [DATA_W-1:0] sh;
        sh = dw >> {lane, 3'b000};
        case (f3)
            3'b000:  return {{56{sh[7]}},  sh[7:0]};
            3'b001:  return {{48{sh[15]}}, sh[15:0]};
            3'b010:  return {{32{sh[31]}}, sh[31:0]};
            3'b100:  return {56'd0, sh[7:0]};
            3'b101:  return {48'd0, sh[15:0]};
            3'b110:  return {32'd0, sh[31:0]};
            default: return sh;
        endcase
    endfunction

    function automatic logic [3:0] size_mask(input logic [1:0] size);
        case (size)
            2'b00:   return 4'b0001;
            2'b01:   return 4'b0010;
            2'b10:   return 4'b0100;
            default: return 4'b1000;
        endcase
    endfunction

`ifdef MISALIGN_TRAP_EN
    always_comb begin
        case (req_funct3[1:0])
            2'b01:   req_misaligned = req_addr[0];
            2'b10:   req_misaligned = |req_addr[1:0];
            2'b11:   req_misaligned = |req_addr[2:0];
            default: req_misaligned = 1'b0;
        endcase
    end
`else
    assign req_misaligned = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        funct3_d     = funct3_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        mem_ren_d    = mem_ren_q;
        mem_raddr_d  = mem_raddr_q;
        mem_wen_d    = mem_wen_q;
        mem_waddr_d  = mem_waddr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_wmask_d  = mem_wmask_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    funct3_d     = req_funct3;
                    cnt_d        = 4'd0;
                    req_ready_d  = 1'b0;
                    resp_err_d   = 1'b0;
                    resp_rdata_d = '0;
                    if (req_misaligned) begin
                        // Trapped accesses never touch memory
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else if (req_we) begin
                        state_d     = WR;
                        mem_wen_d   = 1'b1;
                        mem_waddr_d = req_addr;
                        mem_wdata_d = req_wdata << {req_addr[2:0], 3'b000};
                        mem_wmask_d = size_mask(req_funct3[1:0]);
                    end else begin
                        state_d     = RD;
                        mem_ren_d   = 1'b1;
                        mem_raddr_d = req_addr;
                    end
                end
            end
            RD: begin
                if (cnt_q == LAST_CNT) begin
                    state_d      = RESP;
                    mem_ren_d    = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = load_extend(funct3_q, mem_rdata, mem_raddr_q[2:0]);
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            WR: begin
                state_d      = RESP;
                mem_wen_d    = 1'b0;
                resp_valid_d = 1'b1;
            end
            RESP: begin
                if (resp_ready) begin
                    state_d      = IDLE;
                    resp_valid_d = 1'b0;
                    req_ready_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            funct3_q     <= 3'd0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            mem_ren_q    <= 1'b0;
            mem_raddr_q  <= '0;
            mem_wen_q    <= 1'b0;
            mem_waddr_q  <= '0;
            mem_wdata_q  <= '0;
            mem_wmask_q  <= 4'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            funct3_q     <= funct3_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            mem_ren_q    <= mem_ren_d;
            mem_raddr_q  <= mem_raddr_d;
            mem_wen_q    <= mem_wen_d;
            mem_waddr_q  <= mem_waddr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_wmask_q  <= mem_wmask_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign mem_ren    = mem_ren_q;
    assign mem_raddr  = mem_raddr_q;
    assign mem_wen    = mem_wen_q;
    assign mem_waddr  = mem_waddr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_wmask  = mem_wmask_q;

endmodule
